// File: rtl/slice_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slice_bank_pkg
// Summary  : shared FSM encoding, default sizes and index-width helper
// Revision : 1.0
// ============================================================================
package slice_bank_pkg;

   localparam int NREQ_DEF   = 3;
   localparam int NSLICE_DEF = 3;
   localparam int SW_DEF     = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Width of an index into n entries, never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/slice_bank_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Summary  : one-hot round-robin grant, search starts just above i_ptr
// Revision : 1.0
// ============================================================================
module rr_arbiter
   import slice_bank_pkg::*;
#(
   parameter int N  = NREQ_DEF,
   parameter int PW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant
);

   logic [N-1:0] w_mask;
   logic [N-1:0] w_hi;
   logic [N-1:0] w_pick;

   // Requests above the pointer win first; otherwise wrap to the lowest index.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_mask[i] = (i > int'(i_ptr));
      end
      w_hi    = i_req & w_mask;
      w_pick  = (|w_hi) ? w_hi : i_req;
      o_grant = w_pick & (~w_pick + N'(1));
   end

endmodule
`default_nettype wire

// File: rtl/slice_bank_sched.sv
`default_nettype none
// ============================================================================
// Module   : slice_bank_sched
// Summary  : arbitrated writes into a registered slice bank, serial flush
// Revision : 1.0
// ============================================================================
module slice_bank_sched
   import slice_bank_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int NSLICE = NSLICE_DEF,
   parameter int SW     = SW_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ-1:0][1:0]         req_slice,
   input  logic [NREQ-1:0][SW-1:0]      req_data,
   output logic [NREQ-1:0]              req_ready,
   input  logic                         flush_req,
   output logic                         flush_busy,
   output logic [0:NSLICE-1][SW-1:0]    bank,
   output logic [NSLICE-1:0]            bank_valid,
   output logic                         err_slice
);

   localparam int PW = idx_w(NREQ);
   localparam int CW = idx_w(NSLICE);

   state_t                      state_q, state_d;
   logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]               win_q, win_d;
   logic [1:0]                  slice_q, slice_d;
   logic [SW-1:0]               data_q, data_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [0:NSLICE-1][SW-1:0]   bank_q, bank_d;
   logic [NSLICE-1:0]           bank_valid_q, bank_valid_d;
   logic [NREQ-1:0]             w_grant;
   logic                        w_slice_ok;

   rr_arbiter #(
      .N  (NREQ),
      .PW (PW)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (rr_ptr_q),
      .o_grant (w_grant)
   );

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      win_d        = win_q;
      slice_d      = slice_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      bank_d       = bank_q;
      bank_valid_d = bank_valid_q;
      req_ready    = '0;
      flush_busy   = 1'b0;
      err_slice    = 1'b0;
      w_slice_ok   = (int'(slice_q) < NSLICE);

      case (state_q)
         ST_IDLE: begin
            if (!rst) begin
               if (flush_req) begin
                  state_d = ST_FLUSH;
               end else if (|req_valid) begin
                  req_ready = w_grant;
                  state_d   = ST_WRITE;
                  for (int i = 0; i < NREQ; i++) begin
                     if (w_grant[i]) begin
                        win_d   = PW'(i);
                        slice_d = req_slice[i];
                        data_d  = req_data[i];
                     end
                  end
               end
            end
         end
         ST_WRITE: begin
            if (w_slice_ok) begin
               for (int s = 0; s < NSLICE; s++) begin
                  if (int'(slice_q) == s) begin
                     bank_d[s]       = data_q;
                     bank_valid_d[s] = 1'b1;
                  end
               end
            end else begin
               err_slice = !rst;
            end
            rr_ptr_d = win_q;
            state_d  = ST_IDLE;
         end
         ST_FLUSH: begin
            flush_busy = 1'b1;
            for (int s = 0; s < NSLICE; s++) begin
               if (int'(cnt_q) == s) begin
                  bank_d[s]       = '0;
                  bank_valid_d[s] = 1'b0;
               end
            end
            if (int'(cnt_q) == NSLICE - 1) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= PW'(NREQ - 1);
         win_q        <= '0;
         slice_q      <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         bank_q       <= '0;
         bank_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         win_q        <= win_d;
         slice_q      <= slice_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         bank_q       <= bank_d;
         bank_valid_q <= bank_valid_d;
      end
   end

   assign bank       = bank_q;
   assign bank_valid = bank_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_slice_bank_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_slice_bank_sched
// Summary  : directed self-checking bench for slice_bank_sched
// Revision : 1.0
// ============================================================================
module tb_slice_bank_sched;

   logic                 clk;
   logic                 rst;
   logic [2:0]           req_valid;
   logic [2:0][1:0]      req_slice;
   logic [2:0][4:0]      req_data;
   logic [2:0]           req_ready;
   logic                 flush_req;
   logic                 flush_busy;
   logic [0:2][4:0]      bank;
   logic [2:0]           bank_valid;
   logic                 err_slice;

   int n_tests = 0;
   int n_fail  = 0;

   slice_bank_sched #(
      .NREQ   (3),
      .NSLICE (3),
      .SW     (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_slice  (req_slice),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .flush_req  (flush_req),
      .flush_busy (flush_busy),
      .bank       (bank),
      .bank_valid (bank_valid),
      .err_slice  (err_slice)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_slice = '0;
      req_data  = '0;
      flush_req = 1'b0;
      tick();
      req_valid = 3'b111;
      tick();
      check("ready_in_reset", 32'(req_ready), 32'h0);
      rst       = 1'b0;
      req_valid = '0;
      #1;
      check("rst_bank", 32'(bank), 32'h0);
      check("rst_bank_valid", 32'(bank_valid), 32'h0);
      check("rst_flush_busy", 32'(flush_busy), 32'h0);
      check("rst_err", 32'(err_slice), 32'h0);

      // Two requesters, requester 0 first after reset
      req_valid    = 3'b101;
      req_slice[0] = 2'd1; req_data[0] = 5'h0A;
      req_slice[2] = 2'd2; req_data[2] = 5'h15;
      #1;
      check("t1_grant0", 32'(req_ready), 32'h1);
      tick();
      check("t1_write_ready", 32'(req_ready), 32'h0);
      req_valid = 3'b100;
      tick();
      check("t1_bank1", 32'(bank[1]), 32'h0A);
      check("t1_valid", 32'(bank_valid), 32'h2);
      check("t1_grant2", 32'(req_ready), 32'h4);
      tick();
      req_valid = 3'b000;
      tick();
      check("t1_bank2", 32'(bank[2]), 32'h15);
      check("t1_valid2", 32'(bank_valid), 32'h6);

      // All requesters continuously valid
      req_slice[0] = 2'd0; req_data[0] = 5'h04;
      req_slice[1] = 2'd1; req_data[1] = 5'h0B;
      req_slice[2] = 2'd2; req_data[2] = 5'h12;
      req_valid    = 3'b111;
      #1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
         tick();
         check($sformatf("t2_gap%0d", k), 32'(req_ready), 32'h0);
         tick();
      end
      req_valid = 3'b000;
      check("t2_bank0", 32'(bank[0]), 32'h04);
      check("t2_bank1", 32'(bank[1]), 32'h0B);
      check("t2_bank2", 32'(bank[2]), 32'h12);
      check("t2_valid", 32'(bank_valid), 32'h7);
      check("t2_err_idle", 32'(err_slice), 32'h0);

      // Out-of-range slice index
      req_slice[1] = 2'd3; req_data[1] = 5'h1F;
      req_valid    = 3'b010;
      #1;
      check("t3_grant1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 3'b000;
      check("t3_err_hi", 32'(err_slice), 32'h1);
      tick();
      check("t3_err_lo", 32'(err_slice), 32'h0);
      check("t3_bank", 32'(bank), 32'({5'h04, 5'h0B, 5'h12}));
      check("t3_valid", 32'(bank_valid), 32'h7);

      // Flush has priority over a pending request
      req_slice[0] = 2'd0; req_data[0] = 5'h07;
      req_valid    = 3'b001;
      flush_req    = 1'b1;
      #1;
      check("t4_no_grant", 32'(req_ready), 32'h0);
      check("t4_busy_idle", 32'(flush_busy), 32'h0);
      tick();
      flush_req = 1'b0;
      check("t4_busy_c0", 32'(flush_busy), 32'h1);
      check("t4_ready_c0", 32'(req_ready), 32'h0);
      check("t4_bank_c0", 32'(bank[0]), 32'h04);
      tick();
      check("t4_busy_c1", 32'(flush_busy), 32'h1);
      check("t4_bank0_clr", 32'(bank[0]), 32'h0);
      check("t4_bank1_kept", 32'(bank[1]), 32'h0B);
      check("t4_valid_c1", 32'(bank_valid), 32'h6);
      tick();
      check("t4_busy_c2", 32'(flush_busy), 32'h1);
      check("t4_valid_c2", 32'(bank_valid), 32'h4);
      check("t4_bank2_kept", 32'(bank[2]), 32'h12);
      tick();
      check("t4_busy_done", 32'(flush_busy), 32'h0);
      check("t4_bank_clr", 32'(bank), 32'h0);
      check("t4_valid_clr", 32'(bank_valid), 32'h0);
      check("t4_grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 3'b000;
      tick();
      check("t4_bank0_new", 32'(bank[0]), 32'h07);
      check("t4_valid_new", 32'(bank_valid), 32'h1);

      // Reset in the middle of a flush
      req_slice[1] = 2'd2; req_data[1] = 5'h19;
      req_valid    = 3'b010;
      #1;
      check("t5_grant1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 3'b000;
      tick();
      check("t5_bank2", 32'(bank[2]), 32'h19);
      check("t5_valid", 32'(bank_valid), 32'h5);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      check("t5_busy_c0", 32'(flush_busy), 32'h1);
      tick();
      check("t5_busy_c1", 32'(flush_busy), 32'h1);
      check("t5_bank2_c1", 32'(bank[2]), 32'h19);
      rst       = 1'b1;
      req_valid = 3'b111;
      #1;
      check("t5_ready_rst", 32'(req_ready), 32'h0);
      tick();
      rst = 1'b0;
      #1;
      check("t5_busy_after", 32'(flush_busy), 32'h0);
      check("t5_bank_after", 32'(bank), 32'h0);
      check("t5_valid_after", 32'(bank_valid), 32'h0);
      check("t5_prio0", 32'(req_ready), 32'h1);
      req_valid = 3'b000;

      // Same slice written twice; flush_req raised only during WRITE
      req_slice[0] = 2'd0; req_data[0] = 5'h03;
      req_valid    = 3'b001;
      #1;
      check("t6_grant_a", 32'(req_ready), 32'h1);
      tick();
      flush_req = 1'b1;
      #1;
      check("t6_busy_write", 32'(flush_busy), 32'h0);
      tick();
      flush_req   = 1'b0;
      req_data[0] = 5'h1C;
      #1;
      check("t6_bank0_a", 32'(bank[0]), 32'h03);
      check("t6_grant_b", 32'(req_ready), 32'h1);
      check("t6_no_flush", 32'(flush_busy), 32'h0);
      tick();
      req_valid = 3'b000;
      check("t6_busy_w2", 32'(flush_busy), 32'h0);
      tick();
      check("t6_bank0_b", 32'(bank[0]), 32'h1C);
      check("t6_valid", 32'(bank_valid), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
